// File: rtl/bev_pkg.sv
// rtl/bev_pkg.sv - shared camera-mux types and constants for the BEV pixel path
package bev_pkg;

  localparam int NUM_CAM        = 4;
  localparam int CAM_ID_W       = 2;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_X_W        = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_Y_W        = $clog2(DEF_IMG_HEIGHT);

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    rgb565_t              data;
    logic [DEF_X_W-1:0]   x;
    logic [DEF_Y_W-1:0]   y;
    logic                 sof;
  } tagged_pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous show-ahead FIFO; full is judged before a same-cycle read
module pixel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/multi_camera_pixel_mux.sv
// rtl/multi_camera_pixel_mux.sv - tags four camera streams with (x,y) and merges them round-robin
// Optional per-camera drop counters are built when MUX_DROP_COUNT_EN is defined.
module multi_camera_pixel_mux
  import bev_pkg::*;
#(
  parameter int  IMG_WIDTH  = 640,
  parameter int  IMG_HEIGHT = 480,
  parameter int  FIFO_DEPTH = 8,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  rgb565_t [NUM_CAM-1:0]       pixel_data,
  input  logic    [NUM_CAM-1:0]       pixel_valid,
  input  logic    [NUM_CAM-1:0]       frame_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic    [15:0]              out_data,
  output logic    [CAM_ID_W-1:0]      out_cam,
  output logic    [XW-1:0]            out_x,
  output logic    [YW-1:0]            out_y,
  output logic                        out_sof,
  output logic    [NUM_CAM-1:0]       overflow,
  output logic    [NUM_CAM-1:0]       frame_err
`ifdef MUX_DROP_COUNT_EN
  ,output logic   [NUM_CAM-1:0][15:0] drop_count
`endif
);

  typedef struct packed {
    rgb565_t       data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [NUM_CAM-1:0] fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [NUM_CAM-1:0] cand, grant_oh, drop_ovf, drop_fe;
  entry_t             fifo_dout [NUM_CAM];
  entry_t             cand_data [NUM_CAM];

  logic                free;
  logic                found;
  logic [CAM_ID_W-1:0] gnt_idx, idx;
  entry_t              sel;

  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_data_q, out_data_d;
  logic [CAM_ID_W-1:0] out_cam_q, out_cam_d;
  logic [XW-1:0]       out_x_q, out_x_d;
  logic [YW-1:0]       out_y_q, out_y_d;
  logic                out_sof_q, out_sof_d;
  logic [CAM_ID_W-1:0] rr_q, rr_d;
  logic [NUM_CAM-1:0]  overflow_q, frame_err_q;

  for (genvar i = 0; i < NUM_CAM; i++) begin : g_cam
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          full_frame_q, full_frame_d;
    logic          wr_ok;
    entry_t        wr_entry;

    always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      full_frame_d = full_frame_q;
      if (frame_done[i]) begin
        x_d          = '0;
        y_d          = '0;
        full_frame_d = 1'b0;
      end else if (pixel_valid[i] && !full_frame_q) begin
        if (x_q == XW'(IMG_WIDTH - 1)) begin
          if (y_q == YW'(IMG_HEIGHT - 1)) begin
            full_frame_d = 1'b1;
          end else begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        x_q          <= '0;
        y_q          <= '0;
        full_frame_q <= 1'b0;
      end else begin
        x_q          <= x_d;
        y_q          <= y_d;
        full_frame_q <= full_frame_d;
      end
    end

    assign wr_ok       = pixel_valid[i] && !full_frame_q && !fifo_full[i];
    assign drop_fe[i]  = pixel_valid[i] && full_frame_q;
    assign drop_ovf[i] = pixel_valid[i] && !full_frame_q && fifo_full[i];
    assign wr_entry    = {pixel_data[i], x_q, y_q, (x_q == '0) && (y_q == '0)};

    // An empty FIFO lets an arriving pixel bypass straight into the output register.
    assign cand[i]      = !fifo_empty[i] || wr_ok;
    assign cand_data[i] = fifo_empty[i] ? wr_entry : fifo_dout[i];
    assign fifo_wr[i]   = wr_ok && !(grant_oh[i] && fifo_empty[i]);
    assign fifo_rd[i]   = grant_oh[i] && !fifo_empty[i];

    pixel_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr[i]),
      .wr_data (wr_entry),
      .rd_en   (fifo_rd[i]),
      .rd_data (fifo_dout[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  assign free = !out_valid_q || out_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CAM; k++) begin
      idx = rr_q + CAM_ID_W'(k);
      if (!found && cand[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign grant_oh = (free && found) ? (NUM_CAM'(1) << gnt_idx) : '0;
  assign sel      = cand_data[gnt_idx];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cam_d   = out_cam_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_sof_d   = out_sof_q;
    rr_d        = rr_q;
    if (free) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = sel.data;
        out_cam_d  = gnt_idx;
        out_x_d    = sel.x;
        out_y_d    = sel.y;
        out_sof_d  = sel.sof;
        rr_d       = gnt_idx + CAM_ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cam_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_sof_q   <= 1'b0;
      rr_q        <= '0;
      overflow_q  <= '0;
      frame_err_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cam_q   <= out_cam_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_sof_q   <= out_sof_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_q | drop_ovf;
      frame_err_q <= frame_err_q | drop_fe;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cam   = out_cam_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_sof   = out_sof_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

`ifdef MUX_DROP_COUNT_EN
  logic [NUM_CAM-1:0][15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CAM; i++) begin
        if ((drop_ovf[i] || drop_fe[i]) && (drop_cnt_q[i] != 16'hFFFF))
          drop_cnt_q[i] <= drop_cnt_q[i] + 16'd1;
      end
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multi_camera_pixel_mux.sv
// tb/tb_multi_camera_pixel_mux.sv - scoreboard bench: directed pixel streams, queued expectations
module tb_multi_camera_pixel_mux;

  typedef struct {
    logic [1:0]  cam;
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default image size
  logic [3:0][15:0] pixel_data_a;
  logic [3:0]       pixel_valid_a, frame_done_a;
  logic             out_valid_a, out_ready_a, out_sof_a;
  logic [15:0]      out_data_a;
  logic [1:0]       out_cam_a;
  logic [9:0]       out_x_a;
  logic [8:0]       out_y_a;
  logic [3:0]       overflow_a, frame_err_a;
  // Instance B: 4x2 image to exercise line wrap and full-frame
  logic [3:0][15:0] pixel_data_b;
  logic [3:0]       pixel_valid_b, frame_done_b;
  logic             out_valid_b, out_ready_b, out_sof_b;
  logic [15:0]      out_data_b;
  logic [1:0]       out_cam_b;
  logic [1:0]       out_x_b;
  logic [0:0]       out_y_b;
  logic [3:0]       overflow_b, frame_err_b;
`ifdef MUX_DROP_COUNT_EN
  logic [3:0][15:0] drop_count_a, drop_count_b;
`endif

  multi_camera_pixel_mux u_dut_a (
    .clk(clk), .rst(rst), .pixel_data(pixel_data_a), .pixel_valid(pixel_valid_a),
    .frame_done(frame_done_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_cam(out_cam_a), .out_x(out_x_a), .out_y(out_y_a),
    .out_sof(out_sof_a), .overflow(overflow_a), .frame_err(frame_err_a)
`ifdef MUX_DROP_COUNT_EN
    , .drop_count(drop_count_a)
`endif
  );

  multi_camera_pixel_mux #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .pixel_data(pixel_data_b), .pixel_valid(pixel_valid_b),
    .frame_done(frame_done_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_cam(out_cam_b), .out_x(out_x_b), .out_y(out_y_b),
    .out_sof(out_sof_b), .overflow(overflow_b), .frame_err(frame_err_b)
`ifdef MUX_DROP_COUNT_EN
    , .drop_count(drop_count_b)
`endif
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input int cam, input logic [15:0] d, input int x, input int y, input bit sof);
    exp_t e;
    e.cam = 2'(cam); e.data = d; e.x = 10'(x); e.y = 9'(y); e.sof = sof;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word_a: got cam=%0d data=%h x=%0d y=%0d, nothing expected",
                 out_cam_a, out_data_a, out_x_a, out_y_a);
      end else begin
        e_a = q_a.pop_front();
        if ({out_cam_a, out_data_a, out_x_a, out_y_a, out_sof_a} !== {e_a.cam, e_a.data, e_a.x, e_a.y, e_a.sof}) begin
          n_err++;
          $display("FAIL word_a: got cam=%0d data=%h x=%0d y=%0d sof=%0d expected cam=%0d data=%h x=%0d y=%0d sof=%0d",
                   out_cam_a, out_data_a, out_x_a, out_y_a, out_sof_a, e_a.cam, e_a.data, e_a.x, e_a.y, e_a.sof);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word_b: got cam=%0d data=%h x=%0d y=%0d, nothing expected",
                 out_cam_b, out_data_b, out_x_b, out_y_b);
      end else begin
        e_b = q_b.pop_front();
        if ({out_cam_b, out_data_b, 8'b0, out_x_b, 8'b0, out_y_b, out_sof_b} !== {e_b.cam, e_b.data, e_b.x, e_b.y, e_b.sof}) begin
          n_err++;
          $display("FAIL word_b: got cam=%0d data=%h x=%0d y=%0d sof=%0d expected cam=%0d data=%h x=%0d y=%0d sof=%0d",
                   out_cam_b, out_data_b, out_x_b, out_y_b, out_sof_b, e_b.cam, e_b.data, e_b.x, e_b.y, e_b.sof);
        end
      end
    end
  end

  task automatic send_a(input int cam, input logic [15:0] d, input logic v, input logic fd);
    pixel_data_a[cam]  = d;
    pixel_valid_a[cam] = v;
    frame_done_a[cam]  = fd;
    @(posedge clk); #1;
    pixel_valid_a = '0;
    frame_done_a  = '0;
  endtask

  task automatic send_b(input int cam, input logic [15:0] d, input logic v, input logic fd);
    pixel_data_b[cam]  = d;
    pixel_valid_b[cam] = v;
    frame_done_b[cam]  = fd;
    @(posedge clk); #1;
    pixel_valid_b = '0;
    frame_done_b  = '0;
  endtask

  task automatic drain_a(input int bound);
    int n = 0;
    while (q_a.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_a.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout_a: got %0d words outstanding expected 0", q_a.size());
      q_a.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic drain_b(input int bound);
    int n = 0;
    while (q_b.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_b.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout_b: got %0d words outstanding expected 0", q_b.size());
      q_b.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_a(input string name);
    chk(name, {out_valid_a, out_data_a, out_cam_a, out_x_a, out_y_a, out_sof_a, overflow_a, frame_err_a}, 64'd0);
`ifdef MUX_DROP_COUNT_EN
    chk({name, "_drop_count"}, drop_count_a, 64'd0);
`endif
  endtask

  task automatic reset_a();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_a("reset_state_a");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    pixel_data_a = '0; pixel_valid_a = '0; frame_done_a = '0; out_ready_a = 1'b1;
    pixel_data_b = '0; pixel_valid_b = '0; frame_done_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_a("initial_reset_a");
    chk("initial_reset_b", {out_valid_b, out_data_b, out_x_b, out_y_b, out_sof_b, overflow_b, frame_err_b}, 64'd0);

    // Round robin: two simultaneous bursts from all cameras
    for (int i = 0; i < 4; i++) begin
      pixel_data_a[i] = 16'hA000 + 16'(i);
      q_a.push_back(mk(i, 16'hA000 + 16'(i), 0, 0, 1));
    end
    pixel_valid_a = 4'hF;
    @(posedge clk); #1;
    pixel_valid_a = '0;
    drain_a(20);
    for (int i = 0; i < 4; i++) begin
      pixel_data_a[i] = 16'hA100 + 16'(i);
      q_a.push_back(mk(i, 16'hA100 + 16'(i), 1, 0, 0));
    end
    pixel_valid_a = 4'hF;
    @(posedge clk); #1;
    pixel_valid_a = '0;
    drain_a(20);

    // Single camera 2, latency and coordinates
    reset_a();
    q_a.push_back(mk(2, 16'h0001, 0, 0, 1));
    q_a.push_back(mk(2, 16'h0002, 1, 0, 0));
    q_a.push_back(mk(2, 16'h0003, 2, 0, 0));
    chk("idle_before_first_pixel", out_valid_a, 64'd0);
    send_a(2, 16'h0001, 1'b1, 1'b0);
    chk("latency_one_cycle", out_valid_a, 64'd1);
    send_a(2, 16'h0002, 1'b1, 1'b0);
    send_a(2, 16'h0003, 1'b1, 1'b0);
    drain_a(20);

    // Backpressure and overflow on camera 0
    reset_a();
    out_ready_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 9) q_a.push_back(mk(0, 16'hB000 + 16'(k), k, 0, k == 0));
      send_a(0, 16'hB000 + 16'(k), 1'b1, 1'b0);
    end
    for (int c = 0; c < 10; c++) begin
      chk("hold_stable", {out_valid_a, out_cam_a, out_data_a, out_x_a, out_y_a, out_sof_a},
          {1'b1, 2'd0, 16'hB000, 10'd0, 9'd0, 1'b1});
      @(posedge clk); #1;
    end
    chk("overflow_flag", overflow_a, 64'h1);
    chk("frame_err_clear", frame_err_a, 64'h0);
    out_ready_a = 1'b1;
    drain_a(30);
    q_a.push_back(mk(0, 16'hB00A, 10, 0, 0));
    send_a(0, 16'hB00A, 1'b1, 1'b0);
    drain_a(20);
`ifdef MUX_DROP_COUNT_EN
    chk("drop_count_cam0", drop_count_a, 64'h1);
`endif

    // frame_done coincident with a pixel on camera 3
    for (int k = 0; k < 5; k++) begin
      q_a.push_back(mk(3, 16'hC000 + 16'(k), k, 0, k == 0));
      send_a(3, 16'hC000 + 16'(k), 1'b1, 1'b0);
    end
    q_a.push_back(mk(3, 16'hC005, 5, 0, 0));
    send_a(3, 16'hC005, 1'b1, 1'b1);
    q_a.push_back(mk(3, 16'hC006, 0, 0, 1));
    send_a(3, 16'hC006, 1'b1, 1'b0);
    drain_a(20);

    // Reset with words buffered and flags set
    out_ready_a = 1'b0;
    for (int k = 0; k < 3; k++) send_a(1, 16'hE000 + 16'(k), 1'b1, 1'b0);
    chk("valid_before_reset", out_valid_a, 64'd1);
    chk("overflow_before_reset", overflow_a, 64'h1);
    reset_a();
    out_ready_a = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("no_stale_after_reset", out_valid_a, 64'd0);

    // Line wrap and full-frame on the small instance, camera 1
    for (int k = 0; k < 8; k++) begin
      q_b.push_back(mk(1, 16'hD000 + 16'(k), k % 4, k / 4, k == 0));
      send_b(1, 16'hD000 + 16'(k), 1'b1, 1'b0);
    end
    send_b(1, 16'hD008, 1'b1, 1'b0);
    drain_b(20);
    chk("frame_err_b", frame_err_b, 64'h2);
    chk("overflow_b_clear", overflow_b, 64'h0);
    send_b(1, 16'h0000, 1'b0, 1'b1);
    q_b.push_back(mk(1, 16'hD009, 0, 0, 1));
    send_b(1, 16'hD009, 1'b1, 1'b0);
    drain_b(20);
`ifdef MUX_DROP_COUNT_EN
    chk("drop_count_b", drop_count_b, 64'h0000_0000_0001_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
